// File: rtl/io_periph_if.sv
// CPU-side I/O bus for io_periph: select strobes, register address, write data and read-back data.
// Read data is combinational from the peripheral; there is no backpressure.
interface io_periph_if #(
  parameter int SW_W = 16
);
  logic            switch_ctrl;
  logic            led_ctrl;
  logic            io_read;
  logic            io_write;
  logic [1:0]      addr_sel;
  logic [SW_W-1:0] io_wdata;
  logic [SW_W-1:0] io_rdata;

  modport master (
    output switch_ctrl, led_ctrl, io_read, io_write, addr_sel, io_wdata,
    input  io_rdata
  );

  modport slave (
    input  switch_ctrl, led_ctrl, io_read, io_write, addr_sel, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/io_periph.sv
// Board I/O peripheral: synchronised and debounced switches/button, LED register, sticky press flag and press counter.
// Inputs settle DEBOUNCE_CYCLES+3 edges after a change; reads are combinational, LED writes land on the next edge; never stalls.
module io_periph #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            btn_raw,
  io_periph_if.slave      bus,
  output logic [SW_W-1:0] led,
  output logic            btn_pending
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sw_s1, sw_s2, sw_prev, sw_stable, sw_stable_nxt;
  logic [CNT_W-1:0] sw_cnt, sw_cnt_nxt;

  logic             btn_s1, btn_s2, btn_prev, btn_stable, btn_stable_nxt, btn_stable_d;
  logic [CNT_W-1:0] btn_cnt, btn_cnt_nxt;

  logic [15:0]      btn_count, btn_count_nxt;
  logic             btn_pending_nxt;
  logic [SW_W-1:0]  led_nxt;
  logic             press;
  logic             rd_en;
  logic             rd_clr;

  // Two-flop synchronisers plus the previous-cycle copy used to detect movement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_prev  <= '0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      sw_s1    <= sw_raw;
      sw_s2    <= sw_s1;
      sw_prev  <= sw_s2;
      btn_s1   <= btn_raw;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  always_comb begin
    sw_cnt_nxt    = '0;
    sw_stable_nxt = sw_stable;
    if ((sw_s2 == sw_prev) && (sw_s2 != sw_stable)) begin
      if (sw_cnt == CNT_LAST) begin
        sw_stable_nxt = sw_s2;
      end else begin
        sw_cnt_nxt = sw_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    btn_cnt_nxt    = '0;
    btn_stable_nxt = btn_stable;
    if ((btn_s2 == btn_prev) && (btn_s2 != btn_stable)) begin
      if (btn_cnt == CNT_LAST) begin
        btn_stable_nxt = btn_s2;
      end else begin
        btn_cnt_nxt = btn_cnt + CNT_W'(1);
      end
    end
  end

  assign press  = btn_stable & ~btn_stable_d;
  assign rd_en  = bus.switch_ctrl & bus.io_read;
  assign rd_clr = rd_en & (bus.addr_sel == 2'd1);

  // A press edge in the read-clear cycle must not be lost, so set has priority.
  always_comb begin
    btn_pending_nxt = btn_pending;
    if (press) begin
      btn_pending_nxt = 1'b1;
    end else if (rd_clr) begin
      btn_pending_nxt = 1'b0;
    end
  end

  assign btn_count_nxt = btn_count + {15'd0, press};

  always_comb begin
    led_nxt = led;
    if (bus.led_ctrl && bus.io_write) begin
      led_nxt = bus.io_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_cnt       <= '0;
      sw_stable    <= '0;
      btn_cnt      <= '0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
      btn_pending  <= 1'b0;
      btn_count    <= '0;
      led          <= '0;
    end else begin
      sw_cnt       <= sw_cnt_nxt;
      sw_stable    <= sw_stable_nxt;
      btn_cnt      <= btn_cnt_nxt;
      btn_stable   <= btn_stable_nxt;
      btn_stable_d <= btn_stable;
      btn_pending  <= btn_pending_nxt;
      btn_count    <= btn_count_nxt;
      led          <= led_nxt;
    end
  end

  always_comb begin
    bus.io_rdata = '0;
    if (rd_en) begin
      case (bus.addr_sel)
        2'd0:    bus.io_rdata = sw_stable;
        2'd1:    bus.io_rdata = SW_W'(btn_pending);
        2'd2:    bus.io_rdata = SW_W'(btn_count);
        default: bus.io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_periph.sv
// Scoreboard bench for io_periph with DEBOUNCE_CYCLES=4: stimulus queues expected values,
// a negedge monitor pops and compares on every CPU read strobe or explicit observation request.
module tb_io_periph;
  localparam int SW_W = 16;
  localparam int DB   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [SW_W-1:0] sw_raw;
  logic            btn_raw;
  logic [SW_W-1:0] led;
  logic            btn_pending;
  logic            obs;

  typedef struct {
    string       name;
    int          kind;   // 0 io_rdata, 1 led, 2 btn_pending
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  io_periph_if #(.SW_W(SW_W)) bus();

  io_periph #(.DEBOUNCE_CYCLES(DB), .SW_W(SW_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .bus        (bus),
    .led        (led),
    .btn_pending(btn_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((bus.switch_ctrl && bus.io_read) || obs) begin
      logic [15:0] act;
      exp_t        e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: io_rdata=%h with nothing expected", bus.io_rdata);
      end else begin
        e = q.pop_front();
        case (e.kind)
          1:       act = led;
          2:       act = {15'd0, btn_pending};
          default: act = bus.io_rdata;
        endcase
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string nm, input int k, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic bus_idle();
    bus.switch_ctrl = 1'b0;
    bus.led_ctrl    = 1'b0;
    bus.io_read     = 1'b0;
    bus.io_write    = 1'b0;
    bus.addr_sel    = 2'd0;
    bus.io_wdata    = '0;
  endtask

  task automatic rd(input string nm, input logic [1:0] sel, input logic [15:0] v);
    bus.switch_ctrl = 1'b1;
    bus.io_read     = 1'b1;
    bus.addr_sel    = sel;
    push(nm, 0, v);
    step(1);
    bus_idle();
  endtask

  task automatic chk(input string nm, input int k, input logic [15:0] v);
    push(nm, k, v);
    obs = 1'b1;
    step(1);
    obs = 1'b0;
  endtask

  // Holds an addr 0 read for DB+4 samples: zero until the sample after edge DB+3.
  task automatic sw_window(input string nm, input logic [15:0] prev, input logic [15:0] v);
    bus.switch_ctrl = 1'b1;
    bus.io_read     = 1'b1;
    bus.addr_sel    = 2'd0;
    for (int i = 0; i < DB + 3; i++) push({nm, "_wait"}, 0, prev);
    push({nm, "_new"}, 0, v);
    step(DB + 4);
    bus_idle();
  endtask

  initial begin
    reset   = 1'b1;
    sw_raw  = 16'hFFFF;
    btn_raw = 1'b1;
    obs     = 1'b0;
    bus_idle();
    step(2);

    // Reset state with inputs driven high.
    rd("rst_rdata", 2'd0, 16'h0000);
    chk("rst_led", 1, 16'h0000);
    chk("rst_pending", 2, 16'h0000);
    rd("rst_count", 2'd2, 16'h0000);

    // Release with inputs held: switches appear only after edge 7; button counts one press.
    reset = 1'b0;
    sw_window("rst_rel", 16'h0000, 16'hFFFF);
    sw_raw  = 16'h0000;
    btn_raw = 1'b0;
    step(12);
    rd("sw_back_zero", 2'd0, 16'h0000);
    rd("pend_after_rst", 2'd1, 16'h0001);
    rd("pend_cleared", 2'd1, 16'h0000);
    rd("cnt_after_rst", 2'd2, 16'h0001);

    // Three-cycle glitch is rejected, a held value is accepted after edge 7.
    sw_raw = 16'h00A5;
    step(3);
    sw_raw = 16'h0000;
    step(10);
    rd("glitch_rej", 2'd0, 16'h0000);
    sw_raw = 16'h00A5;
    sw_window("sw_a5", 16'h0000, 16'h00A5);

    // Button press, read-clear, second press.
    btn_raw = 1'b1;
    step(10);
    btn_raw = 1'b0;
    chk("btn_pend_pin", 2, 16'h0001);
    rd("btn_cnt_a", 2'd2, 16'h0002);
    rd("btn_rd_set", 2'd1, 16'h0001);
    rd("btn_rd_clr", 2'd1, 16'h0000);
    step(10);
    btn_raw = 1'b1;
    step(10);
    btn_raw = 1'b0;
    step(10);
    rd("btn_cnt_b", 2'd2, 16'h0003);
    rd("pend_pre_collide", 2'd1, 16'h0001);

    // Press edge lands in the read-clear cycle: read sees 0, set wins.
    btn_raw = 1'b1;
    step(DB + 3);
    rd("collide_rd", 2'd1, 16'h0000);
    chk("collide_pin", 2, 16'h0001);
    rd("collide_after", 2'd1, 16'h0001);
    rd("collide_cnt", 2'd2, 16'h0004);
    btn_raw = 1'b0;
    step(10);

    // LED register writes and non-writes.
    bus.led_ctrl = 1'b1;
    bus.io_write = 1'b1;
    bus.io_wdata = 16'h1234;
    step(1);
    bus_idle();
    chk("led_wr", 1, 16'h1234);
    bus.switch_ctrl = 1'b1;
    bus.io_write    = 1'b1;
    bus.io_wdata    = 16'hFFFF;
    step(1);
    bus_idle();
    chk("led_hold_sw_wr", 1, 16'h1234);
    bus.led_ctrl = 1'b1;
    bus.io_wdata = 16'hBEEF;
    step(1);
    bus_idle();
    chk("led_hold_no_wr", 1, 16'h1234);

    // Read data is zero without io_read and at the reserved address.
    bus.switch_ctrl = 1'b1;
    chk("rdata_no_read", 0, 16'h0000);
    bus_idle();
    rd("rsvd_addr3", 2'd3, 16'h0000);
    rd("sw_a5_again", 2'd0, 16'h00A5);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.btn_count = 16'hFFFF;
    step(2);
    release dut.btn_count;
    rd("cnt_preload", 2'd2, 16'hFFFF);
    btn_raw = 1'b1;
    step(10);
    btn_raw = 1'b0;
    step(10);
    rd("cnt_wrap", 2'd2, 16'h0000);
    chk("wrap_pend", 2, 16'h0001);

    step(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_periph.md
Name: io_periph

Overview:
- Board-side I/O peripheral for the single-cycle CPU; sits between the FPGA pins and the CPU's MemOrIO path.
- Upstream of the CPU, it synchronises and debounces the 16 switches and one button, and supplies io_rdata.
- Downstream of the CPU, it captures io_wdata into the LED register on LED writes.
- Provides a sticky button-pressed flag (cleared by a read) and a press counter, so software can poll.

Parameters:
- DEBOUNCE_CYCLES, 20000, number of consecutive stable clk cycles required before a synchronised input is accepted (min 2)
- SW_W, 16, switch / io data width

Ports:
- clk  in  1  CPU clock (divided clock domain)
- reset  in  1  asynchronous, active-high reset
- sw_raw  in  SW_W  raw switch pins (asynchronous)
- btn_raw  in  1  raw button pin (asynchronous)
- switch_ctrl  in  1  CPU is addressing the input block this cycle
- led_ctrl  in  1  CPU is addressing the LED register this cycle
- io_read  in  1  CPU I/O read strobe
- io_write  in  1  CPU I/O write strobe
- addr_sel  in  2  register select within the input block
- io_wdata  in  SW_W  write data from CPU
- io_rdata  out  SW_W  read data to CPU
- led  out  SW_W  LED register drive
- btn_pending  out  1  sticky button-press flag

Behaviour:
- Reset (async, active-high) clears all state: sync flops, debounced values, counters, led, btn_pending, btn_count.
  - Consequently io_rdata = 0 and led = 0 while reset is high and immediately after.
- Synchroniser: each raw input passes through 2 flops (s1 -> s2); s2 is the synchronised value.
- Debounce, switches (one shared counter sw_cnt, plus an sw_prev register holding s2 from the previous cycle). At each clk edge:
  - if s2 != sw_prev: sw_cnt <= 0 (input still moving)
  - else if s2 != sw_stable: if sw_cnt == DEBOUNCE_CYCLES-1 then sw_stable <= s2 and sw_cnt <= 0, else sw_cnt++
  - else: sw_cnt <= 0
  - sw_prev <= s2 on every edge.
- Button: identical debounce with its own counter, giving btn_stable.
- Latency: with the raw input changed before edge 1 and then held, the new debounced value is visible after edge DEBOUNCE_CYCLES+3.
- A glitch that lasts fewer than DEBOUNCE_CYCLES cycles never reaches sw_stable / btn_stable.
- Press detection: a rising edge of btn_stable (registered previous value 0, current value 1) does both:
  - sets btn_pending = 1
  - increments btn_count (16 bit, wraps 0xFFFF -> 0x0000)
- io_rdata is combinational from registered state.
  - It is non-zero only when switch_ctrl & io_read; otherwise it is 0.
  - addr_sel 0: sw_stable
  - addr_sel 1: {15'b0, btn_pending}
  - addr_sel 2: btn_count
  - addr_sel 3: 0
- Read-clear: at a clk edge with switch_ctrl & io_read & addr_sel==1, btn_pending <= 0.
  - The value read in that cycle is the pre-clear value.
  - If a press edge occurs in the same cycle, set wins and btn_pending stays 1.
- LED write: at a clk edge with led_ctrl & io_write, led <= io_wdata. Otherwise led holds.
  - io_write with switch_ctrl only has no effect.
  - led_ctrl and switch_ctrl asserted together is illegal software; the block still performs both actions independently.
- Reset asserted mid-debounce abandons the count. After release, inputs are re-synchronised from 0 and must again be stable for the full window.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset with sw_raw=16'hFFFF and btn_raw=1 -> led=0, io_rdata=0, btn_pending=0 while asserted. After release with inputs held, a read at addr 0 returns 16'hFFFF only after edge 7.
- Glitch rejection: sw_raw 0 -> 16'h00A5 for 3 cycles -> back to 0 -> addr 0 read stays 0. Then hold 16'h00A5 -> read returns 16'h00A5 after edge 7 counted from the change.
- Button: btn_raw high for 10 cycles -> btn_pending=1 and btn_count=1. Read addr 1 returns 1; the next read returns 0. A second press gives btn_count=2.
- Read-clear collision: time the debounced press edge to coincide with the addr 1 read-clear cycle -> that read returns the pre-clear value, and btn_pending=1 afterwards.
- LED: led_ctrl=1 and io_write=1 with io_wdata=16'h1234 -> led=16'h1234 after the edge. Then io_write=1 with led_ctrl=0 and io_wdata=16'hFFFF -> led stays 16'h1234.
- Counter wrap: preload or press until btn_count=16'hFFFF, then one more press -> btn_count=0 and btn_pending=1.
